flex_sync_fifo: RTL and testbench
=================================

Name: flex_sync_fifo

Overview:
- Single-clock, parametrised FIFO for buffering JTAG scan and debug data between TAP-side logic and the bus-side interface.
- Generalises the team's raw FIFO storage array by adding:
  - arbitrary (non-power-of-2) depth
  - internal read/write pointers and an occupancy counter
  - full/empty and programmable almost-full/almost-empty flags
  - sticky overflow/underflow error flags
  - synchronous flush
- Sits directly behind the DR shift path as the standard buffering primitive for same-clock domains.

Parameters:
DATA_WIDTH, 8, width of each entry in bits (>=1)
DEPTH, 16, number of entries (>=2, need not be a power of 2)
AFULL_THRESH, DEPTH-2, almost_full asserted when count >= AFULL_THRESH
AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH

Ports:
clk  input  1  sole clock, rising-edge
rst  input  1  asynchronous reset, active-high
clear  input  1  synchronous flush
wen  input  1  write request
wdata  input  DATA_WIDTH  write data
ren  input  1  read request
rdata  output  DATA_WIDTH  read data
rvalid  output  1  rdata valid
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: write rejected
underflow  output  1  sticky: read rejected

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: wptr=0, rptr=0, count=0, rdata=0, rvalid=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_empty=1, almost_full=(AFULL_THRESH==0).
- Storage array is not reset.
- Accept rules, evaluated each rising edge:
  - rd_acc = ren & ~empty
  - wr_acc = wen & (~full | rd_acc)
  - Write while full is accepted only together with an accepted read. Count is unchanged, the read returns the old head, and the new word lands in the freed slot.
  - Write and read while empty: write accepted, read rejected.
- Pointers advance by 1 on each accept and wrap from DEPTH-1 to 0 (explicit compare, no power-of-2 masking).
- count update: +1 if wr_acc & ~rd_acc; -1 if rd_acc & ~wr_acc; else unchanged.
- Flags full, empty, almost_full, almost_empty are combinational decodes of registered count; no extra latency.
- Standard read mode (macro undefined):
  - rd_acc registers mem[rptr] into rdata on the same edge.
  - rvalid=1 for exactly the following cycle; read latency is 1.
  - rdata holds its last value when no read occurs.
- Errors:
  - wen & ~wr_acc sets overflow.
  - ren & ~rd_acc sets underflow.
  - Both flags stay set until clear or rst.
- clear, synchronous:
  - Next edge: pointers=0, count=0, rvalid=0, overflow=0, underflow=0.
  - rdata unchanged.
  - clear overrides wen/ren in the same cycle: nothing accepted, no flags set.
- Reset mid-operation: immediate return to reset values regardless of clk; contents are discarded logically.

Optional Feature:
- Macro FLEX_SYNC_FIFO_FWFT_EN selects first-word fall-through mode.
- Defined:
  - rdata = mem[rptr] combinationally, and rvalid = ~empty.
  - ren with rvalid=1 pops the head; the next word appears the cycle after the pop.
  - A word written into an empty FIFO is visible on rdata the cycle after the write edge.
  - rdata reads 0 after reset while empty.
  - Accept, count and error rules are unchanged.
- Undefined: standard 1-cycle registered read as described above.

Test Plan:
- Fill/drain, DEPTH=16: write 0x00..0x0F -> full=1, count=16, almost_full from count 14. Read 16 times -> rdata 0x00..0x0F in order, each one cycle after ren, then empty=1.
- Overflow/underflow: 17th write while full -> rejected, overflow=1, count=16. Read on empty -> underflow=1, rvalid=0. clear -> both flags 0, count=0.
- Full with simultaneous wen+ren: write 0xAA -> read returns head, 0xAA stored, count stays 16, overflow stays 0. Draining later yields 0xAA last.
- Wrap with DEPTH=5: perform 12 interleaved write/read pairs -> data ordered correctly across two pointer wraps; count never exceeds 5.
- Async reset mid-burst: assert rst between edges with count=7 -> count=0, empty=1, rvalid=0 immediately, without waiting for an edge. First write after release is read back first.
- FWFT build: write 0x3C into empty -> next cycle rvalid=1, rdata=0x3C with no ren. ren pops -> empty=1.

Source files
------------

// File: rtl/flex_sync_fifo.sv
// flex_sync_fifo: single-clock FIFO with arbitrary depth, occupancy counter,
// full/empty and programmable almost-full/almost-empty flags, sticky
// overflow/underflow errors and a synchronous flush.
// Optional build macro FLEX_SYNC_FIFO_FWFT_EN selects first-word fall-through
// reads; without it rdata is registered with a one-cycle read latency.
module flex_sync_fifo #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         wen,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         ren,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         rvalid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc_c;
    logic             wr_acc_c;

    // Pointer advance with explicit wrap, so any depth works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Status flags decode straight from the registered occupancy.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (32'(count_q) >= AFULL_THRESH);
    assign almost_empty = (32'(count_q) <= AEMPTY_THRESH);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept decisions; a flush suppresses both sides for the cycle.
    assign rd_acc_c = ~clear & ren & ~empty;
    assign wr_acc_c = ~clear & wen & (~full | rd_acc_c);

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc_c) wptr_d = ptr_inc(wptr_q);
            if (rd_acc_c) rptr_d = ptr_inc(rptr_q);
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (wen & ~wr_acc_c) overflow_d  = 1'b1;
            if (ren & ~rd_acc_c) underflow_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array write; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c) mem[wptr_q] <= wdata;
    end

`ifdef FLEX_SYNC_FIFO_FWFT_EN
    // Head word falls through; forced to zero while nothing is stored.
    assign rdata  = empty ? '0 : mem[rptr_q];
    assign rvalid = ~empty;
`else
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    // Registered read: capture the head on an accepted pop, hold otherwise.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (rd_acc_c) begin
            rdata_d  = mem[rptr_q];
            rvalid_d = 1'b1;
        end
    end

    // Read data and valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_flex_sync_fifo.sv
// Directed testbench for flex_sync_fifo: a DEPTH=16 instance for fill/drain,
// error and flush scenarios, and a DEPTH=5 instance for pointer wrap.
module tb_flex_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clear, wen, ren;
    logic [7:0] wdata, rdata;
    logic       rvalid, full, empty, afull, aempty, overflow, underflow;
    logic [4:0] count;

    logic       clear_b, wen_b, ren_b;
    logic [7:0] wdata_b, rdata_b;
    logic       rvalid_b, full_b, empty_b, afull_b, aempty_b, overflow_b, underflow_b;
    logic [2:0] count_b;

    int tests_run    = 0;
    int tests_failed = 0;

    flex_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
        .almost_full(afull), .almost_empty(aempty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    flex_sync_fifo #(.DATA_WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .clear(clear_b), .wen(wen_b), .wdata(wdata_b), .ren(ren_b),
        .rdata(rdata_b), .rvalid(rvalid_b), .full(full_b), .empty(empty_b),
        .almost_full(afull_b), .almost_empty(aempty_b), .count(count_b),
        .overflow(overflow_b), .underflow(underflow_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({count, empty, full, aempty, afull, rvalid, overflow, underflow} !== {5'd0, 7'b1010000}) begin
            tests_failed++;
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b ae=%b af=%b rv=%b ov=%b un=%b, want cnt=0 e=1 f=0 ae=1 af=0 rv=0 ov=0 un=0",
                     count, empty, full, aempty, afull, rvalid, overflow, underflow);
        end
        tests_run++;
        if (rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h want 00", rdata);
        end
        tests_run++;
        if ({count_b, empty_b, full_b} !== {3'd0, 2'b10}) begin
            tests_failed++;
            $display("FAIL reset_dut5: got cnt=%0d e=%b f=%b want cnt=0 e=1 f=0", count_b, empty_b, full_b);
        end
    endtask

`ifdef FLEX_SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        wen = 1'b1; wdata = 8'h3C;
        step();
        wen = 1'b0;
        tests_run++;
        if ({rvalid, rdata, count} !== {1'b1, 8'h3C, 5'd1}) begin
            tests_failed++;
            $display("FAIL fwft_fallthrough: got rv=%b rdata=%h cnt=%0d want rv=1 rdata=3c cnt=1", rvalid, rdata, count);
        end
        ren = 1'b1;
        step();
        ren = 1'b0;
        tests_run++;
        if ({empty, rvalid, rdata} !== {1'b1, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL fwft_pop: got e=%b rv=%b rdata=%h want e=1 rv=0 rdata=00", empty, rvalid, rdata);
        end
    endtask
`else
    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            wen = 1'b1; wdata = 8'(i);
            step();
            tests_run++;
            if ({count, afull} !== {5'(i + 1), 1'((i + 1) >= 14)}) begin
                tests_failed++;
                $display("FAIL fill_%0d: got cnt=%0d af=%b want cnt=%0d af=%b", i, count, afull, i + 1, (i + 1) >= 14);
            end
        end
        wen = 1'b0;
        tests_run++;
        if ({full, empty} !== 2'b10) begin
            tests_failed++;
            $display("FAIL fill_full: got f=%b e=%b want f=1 e=0", full, empty);
        end
        for (int i = 0; i < 16; i++) begin
            ren = 1'b1;
            step();
            tests_run++;
            if ({rvalid, rdata, count} !== {1'b1, 8'(i), 5'(15 - i)}) begin
                tests_failed++;
                $display("FAIL drain_%0d: got rv=%b rdata=%h cnt=%0d want rv=1 rdata=%h cnt=%0d",
                         i, rvalid, rdata, count, 8'(i), 15 - i);
            end
        end
        ren = 1'b0;
        step();
        tests_run++;
        if ({rvalid, empty, aempty, rdata} !== {3'b011, 8'h0F}) begin
            tests_failed++;
            $display("FAIL drain_idle: got rv=%b e=%b ae=%b rdata=%h want rv=0 e=1 ae=1 rdata=0f", rvalid, empty, aempty, rdata);
        end
    endtask

    task automatic test_overflow_underflow();
        ren = 1'b1;
        step();
        ren = 1'b0;
        tests_run++;
        if ({underflow, rvalid, count} !== {2'b10, 5'd0}) begin
            tests_failed++;
            $display("FAIL underflow: got un=%b rv=%b cnt=%0d want un=1 rv=0 cnt=0", underflow, rvalid, count);
        end
        for (int i = 0; i < 16; i++) begin
            wen = 1'b1; wdata = 8'(8'h20 + i);
            step();
        end
        wdata = 8'h55;
        step();
        wen = 1'b0;
        tests_run++;
        if ({overflow, underflow, full, count} !== {3'b111, 5'd16}) begin
            tests_failed++;
            $display("FAIL overflow: got ov=%b un=%b f=%b cnt=%0d want ov=1 un=1 f=1 cnt=16", overflow, underflow, full, count);
        end
        clear = 1'b1; wen = 1'b1;
        step();
        clear = 1'b0; wen = 1'b0;
        tests_run++;
        if ({overflow, underflow, empty, count} !== {3'b001, 5'd0}) begin
            tests_failed++;
            $display("FAIL clear_full: got ov=%b un=%b e=%b cnt=%0d want ov=0 un=0 e=1 cnt=0", overflow, underflow, empty, count);
        end
        wen = 1'b1; wdata = 8'h66;
        step();
        clear = 1'b1; wen = 1'b1; ren = 1'b1;
        step();
        clear = 1'b0; wen = 1'b0; ren = 1'b0;
        tests_run++;
        if ({count, rvalid, overflow, underflow, rdata} !== {5'd0, 3'b000, 8'h0F}) begin
            tests_failed++;
            $display("FAIL clear_override: got cnt=%0d rv=%b ov=%b un=%b rdata=%h want cnt=0 rv=0 ov=0 un=0 rdata=0f",
                     count, rvalid, overflow, underflow, rdata);
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 16; i++) begin
            wen = 1'b1; wdata = 8'(8'h10 + i);
            step();
        end
        wen = 1'b1; ren = 1'b1; wdata = 8'hAA;
        step();
        wen = 1'b0; ren = 1'b0;
        tests_run++;
        if ({count, full, rvalid, overflow, rdata} !== {5'd16, 3'b110, 8'h10}) begin
            tests_failed++;
            $display("FAIL full_rw: got cnt=%0d f=%b rv=%b ov=%b rdata=%h want cnt=16 f=1 rv=1 ov=0 rdata=10",
                     count, full, rvalid, overflow, rdata);
        end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp;
            exp = (i < 15) ? 8'(8'h11 + i) : 8'hAA;
            ren = 1'b1;
            step();
            tests_run++;
            if ({rvalid, rdata} !== {1'b1, exp}) begin
                tests_failed++;
                $display("FAIL full_rw_drain_%0d: got rv=%b rdata=%h want rv=1 rdata=%h", i, rvalid, rdata, exp);
            end
        end
        ren = 1'b0;
        step();
        tests_run++;
        if ({empty, overflow, underflow} !== 3'b100) begin
            tests_failed++;
            $display("FAIL full_rw_end: got e=%b ov=%b un=%b want e=1 ov=0 un=0", empty, overflow, underflow);
        end
    endtask

    task automatic test_wrap();
        wen_b = 1'b1; wdata_b = 8'h80;
        step();
        wdata_b = 8'h81;
        step();
        for (int k = 0; k < 12; k++) begin
            wen_b = 1'b1; ren_b = 1'b1; wdata_b = 8'(8'h82 + k);
            step();
            tests_run++;
            if ({rvalid_b, rdata_b, count_b} !== {1'b1, 8'(8'h80 + k), 3'd2}) begin
                tests_failed++;
                $display("FAIL wrap_%0d: got rv=%b rdata=%h cnt=%0d want rv=1 rdata=%h cnt=2",
                         k, rvalid_b, rdata_b, count_b, 8'(8'h80 + k));
            end
        end
        wen_b = 1'b0; ren_b = 1'b1;
        step();
        tests_run++;
        if ({rdata_b, count_b} !== {8'h8C, 3'd1}) begin
            tests_failed++;
            $display("FAIL wrap_tail0: got rdata=%h cnt=%0d want rdata=8c cnt=1", rdata_b, count_b);
        end
        step();
        ren_b = 1'b0;
        tests_run++;
        if ({rdata_b, count_b, empty_b} !== {8'h8D, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL wrap_tail1: got rdata=%h cnt=%0d e=%b want rdata=8d cnt=0 e=1", rdata_b, count_b, empty_b);
        end
        for (int i = 0; i < 6; i++) begin
            wen_b = 1'b1; wdata_b = 8'(8'h90 + i);
            step();
        end
        wen_b = 1'b0;
        tests_run++;
        if ({full_b, count_b, overflow_b, afull_b} !== {1'b1, 3'd5, 2'b11}) begin
            tests_failed++;
            $display("FAIL wrap_full: got f=%b cnt=%0d ov=%b af=%b want f=1 cnt=5 ov=1 af=1", full_b, count_b, overflow_b, afull_b);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) begin
            wen = 1'b1; wdata = 8'(8'h40 + i);
            step();
        end
        wen = 1'b0; ren = 1'b1;
        step();
        ren = 1'b0;
        tests_run++;
        if ({count, rvalid, rdata} !== {5'd7, 1'b1, 8'h40}) begin
            tests_failed++;
            $display("FAIL async_pre: got cnt=%0d rv=%b rdata=%h want cnt=7 rv=1 rdata=40", count, rvalid, rdata);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({count, empty, rvalid, rdata} !== {5'd0, 2'b10, 8'h00}) begin
            tests_failed++;
            $display("FAIL async_reset: got cnt=%0d e=%b rv=%b rdata=%h want cnt=0 e=1 rv=0 rdata=00", count, empty, rvalid, rdata);
        end
        rst = 1'b0;
        wen = 1'b1; wdata = 8'h77;
        step();
        wdata = 8'h78;
        step();
        wen = 1'b0; ren = 1'b1;
        step();
        ren = 1'b0;
        tests_run++;
        if ({rvalid, rdata, count} !== {1'b1, 8'h77, 5'd1}) begin
            tests_failed++;
            $display("FAIL async_after: got rv=%b rdata=%h cnt=%0d want rv=1 rdata=77 cnt=1", rvalid, rdata, count);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; wen = 1'b0; ren = 1'b0; wdata = 8'h00;
        clear_b = 1'b0; wen_b = 1'b0; ren_b = 1'b0; wdata_b = 8'h00;
        #2;
        test_reset();
        step();
        step();
        rst = 1'b0;
`ifdef FLEX_SYNC_FIFO_FWFT_EN
        test_fwft();
`else
        test_fill_drain();
        test_overflow_underflow();
        test_full_simul();
        test_wrap();
        test_async_reset();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
